// File: rtl/rvj1_sram_arb_pkg.sv
// Shared types for the SRAM arbiter and its round-robin helper.
package rvj1_sram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RDATA  = 2'd2,
        ST_RESP   = 2'd3
    } arb_state_e;

    typedef logic port_t;

    localparam port_t PORT_M0 = 1'b0;
    localparam port_t PORT_M1 = 1'b1;

    localparam int WORD_OFFSET = 2;

endpackage

// File: rtl/rvj1_rr_arb2.sv
// Two-requester round-robin: on a tie the port that was not served last wins.
module rvj1_rr_arb2
    import rvj1_sram_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  port_t      last_i,
    output port_t      grant_o
);

    always_comb begin
        grant_o = PORT_M0;
        unique case (req_i)
            2'b10:   grant_o = PORT_M1;
            2'b11:   grant_o = ~last_i;
            default: grant_o = PORT_M0;
        endcase
    end

endmodule

// File: rtl/rvj1_sram_arbiter.sv
// Shares one 1RW SRAM port between two Wishbone classic slaves with
// round-robin arbitration and registered SRAM control.
module rvj1_sram_arbiter
    import rvj1_sram_arb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR        = 32'h3000_4000,
    parameter int          ADDR_WIDTH_WORDS = 9
) (
    input  logic                        wb_clk_i,
    input  logic                        rstn_i,
    input  logic                        mgmt_only_i,
    input  logic                        m0_cyc_i,
    input  logic                        m0_stb_i,
    input  logic                        m0_we_i,
    input  logic [3:0]                  m0_sel_i,
    input  logic [31:0]                 m0_adr_i,
    input  logic [31:0]                 m0_dat_i,
    output logic                        m0_ack_o,
    output logic [31:0]                 m0_dat_o,
    input  logic                        m1_cyc_i,
    input  logic                        m1_stb_i,
    input  logic                        m1_we_i,
    input  logic [3:0]                  m1_sel_i,
    input  logic [31:0]                 m1_adr_i,
    input  logic [31:0]                 m1_dat_i,
    output logic                        m1_ack_o,
    output logic [31:0]                 m1_dat_o,
    output logic                        sram_clk0_o,
    output logic                        sram_csb0_o,
    output logic                        sram_web0_o,
    output logic [3:0]                  sram_wmask0_o,
    output logic [ADDR_WIDTH_WORDS-1:0] sram_addr0_o,
    output logic [31:0]                 sram_din0_o,
    input  logic [31:0]                 sram_dout0_i
);

    localparam int TAG_LSB = ADDR_WIDTH_WORDS + WORD_OFFSET;

    arb_state_e state_q;
    port_t      grant_q;
    port_t      rr_last_q;
    logic       we_q;
    logic       null_q;

    logic       m0_req;
    logic       m1_req;
    port_t      grant;
    logic       req_we;
    logic [3:0] req_sel;
    logic [31:0] req_adr;
    logic [31:0] req_dat;
    logic       req_inr;
    logic       gnt_cyc;
    logic       unused_adr_lsb;

    assign m0_req = m0_cyc_i & m0_stb_i;
    assign m1_req = m1_cyc_i & m1_stb_i & ~mgmt_only_i;

    rvj1_rr_arb2 u_rr_arb2 (
        .req_i   ({m1_req, m0_req}),
        .last_i  (rr_last_q),
        .grant_o (grant)
    );

    assign req_we  = (grant == PORT_M1) ? m1_we_i  : m0_we_i;
    assign req_sel = (grant == PORT_M1) ? m1_sel_i : m0_sel_i;
    assign req_adr = (grant == PORT_M1) ? m1_adr_i : m0_adr_i;
    assign req_dat = (grant == PORT_M1) ? m1_dat_i : m0_dat_i;
    assign req_inr = req_adr[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB];

    // Abort is judged on the granted master's cyc at the point ack would rise.
    assign gnt_cyc = (grant_q == PORT_M1) ? m1_cyc_i : m0_cyc_i;

    assign sram_clk0_o    = wb_clk_i;
    assign unused_adr_lsb = ^{m0_adr_i[1:0], m1_adr_i[1:0]};

    always_ff @(posedge wb_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q       <= ST_IDLE;
            grant_q       <= PORT_M0;
            rr_last_q     <= PORT_M1;
            we_q          <= 1'b0;
            null_q        <= 1'b0;
            sram_csb0_o   <= 1'b1;
            sram_web0_o   <= 1'b1;
            sram_wmask0_o <= 4'b0;
            sram_addr0_o  <= '0;
            sram_din0_o   <= 32'b0;
            m0_ack_o      <= 1'b0;
            m1_ack_o      <= 1'b0;
            m0_dat_o      <= 32'b0;
            m1_dat_o      <= 32'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (m0_req | m1_req) begin
                        grant_q <= grant;
                        we_q    <= req_we;
                        null_q  <= ~req_inr;
                        if (req_inr) begin
                            sram_csb0_o   <= 1'b0;
                            sram_web0_o   <= ~req_we;
                            sram_wmask0_o <= req_we ? req_sel : 4'b0;
                            sram_addr0_o  <=
                                req_adr[TAG_LSB-1:WORD_OFFSET];
                            sram_din0_o   <= req_dat;
                        end
                        state_q <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    sram_csb0_o <= 1'b1;
                    sram_web0_o <= 1'b1;
                    if (we_q | null_q) begin
                        if (gnt_cyc) begin
                            if (grant_q == PORT_M1) begin
                                m1_ack_o <= 1'b1;
                                if (!we_q) m1_dat_o <= 32'b0;
                            end else begin
                                m0_ack_o <= 1'b1;
                                if (!we_q) m0_dat_o <= 32'b0;
                            end
                        end
                        state_q <= ST_RESP;
                    end else begin
                        state_q <= ST_RDATA;
                    end
                end
                ST_RDATA: begin
                    if (gnt_cyc) begin
                        if (grant_q == PORT_M1) begin
                            m1_ack_o <= 1'b1;
                            m1_dat_o <= sram_dout0_i;
                        end else begin
                            m0_ack_o <= 1'b1;
                            m0_dat_o <= sram_dout0_i;
                        end
                    end
                    state_q <= ST_RESP;
                end
                ST_RESP: begin
                    m0_ack_o  <= 1'b0;
                    m1_ack_o  <= 1'b0;
                    rr_last_q <= grant_q;
                    state_q   <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
